// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, checker state encoding and next-state function
package lfsr_pkg;

    localparam int           DEFAULT_WIDTH = 4;
    localparam logic [3:0]   DEFAULT_TAPS  = 4'b1100;
    localparam logic [3:0]   DEFAULT_SEED  = 4'b1010;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Shift left, feedback bit is the parity of the tapped state bits.
    function automatic logic [DEFAULT_WIDTH-1:0] nxt(
        input logic [DEFAULT_WIDTH-1:0] s,
        input logic [DEFAULT_WIDTH-1:0] taps
    );
        return {s[DEFAULT_WIDTH-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational LFSR next-state, shared with the upstream generator
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    // Shift left and append the parity of the tapped bits.
    assign next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR sequence checker; LFSR_CHK_STUCK_DET_EN adds the sticky all-zero flag
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS        = DEFAULT_TAPS,
    parameter int               LOCK_CNT    = 8,
    parameter int               LOSS_THRESH = 4,
    parameter int               ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             stuck_o
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    chk_state_e         state_q;
    logic [WIDTH-1:0]   expected_q;
    logic [MATCH_W-1:0] match_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic               locked_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic [WIDTH-1:0]   seed_nxt;
    logic [WIDTH-1:0]   exp_nxt;
    logic               word_ok;

    // Successor of the received word, used to (re)seed the prediction.
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_data (
        .state_i (data_i),
        .next_o  (seed_nxt)
    );

    // Successor of the prediction, used while free-running in LOCKED.
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_exp (
        .state_i (expected_q),
        .next_o  (exp_nxt)
    );

    assign word_ok = (data_i == expected_q);

    // Sync FSM: search for a seed, verify LOCK_CNT predictions, then free-run and count errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (clear_i) begin
                err_cnt_q <= '0;
            end
            if (valid_i) begin
                unique case (state_q)
                    SEARCH: begin
                        // The all-zero word is the lock-up state and cannot seed.
                        if (data_i != '0) begin
                            expected_q  <= seed_nxt;
                            match_cnt_q <= '0;
                            state_q     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (word_ok) begin
                            expected_q  <= seed_nxt;
                            match_cnt_q <= match_cnt_q + 1'b1;
                            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                miss_cnt_q <= '0;
                            end
                        end else if (data_i == '0) begin
                            state_q <= SEARCH;
                        end else begin
                            expected_q  <= seed_nxt;
                            match_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Never resync from data here, so corrupt words cannot steer the prediction.
                        expected_q <= exp_nxt;
                        if (word_ok) begin
                            miss_cnt_q <= '0;
                        end else begin
                            err_q      <= 1'b1;
                            miss_cnt_q <= miss_cnt_q + 1'b1;
                            if (!clear_i && (err_cnt_q != '1)) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            if (miss_cnt_q == MISS_W'(LOSS_THRESH - 1)) begin
                                state_q    <= SEARCH;
                                locked_q   <= 1'b0;
                                miss_cnt_q <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_STUCK_DET_EN
    logic stuck_q;

    // Sticky flag: any valid all-zero word in any state, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_q <= 1'b0;
        end else if (valid_i && (data_i == '0)) begin
            stuck_q <= 1'b1;
        end
    end

    assign stuck_o = stuck_q;
`else
    assign stuck_o = 1'b0;
`endif

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule
